// File: rtl/div_seq_unit_if.sv
// Operand/result handshake bundle for the sequential divider.
// Latency: none (pure wiring).
// Backpressure: in_ready/out_ready carry flow control in each direction.
interface div_seq_unit_if #(
    parameter int a_width = 8,
    parameter int b_width = 8
) ();
    logic               in_valid;
    logic               in_ready;
    logic               tc;
    logic [a_width-1:0] a;
    logic [b_width-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [a_width-1:0] quotient;
    logic [b_width-1:0] remainder;
    logic [b_width-1:0] modulus;
    logic               div_by_zero;

    // Producer/consumer side of the divider.
    modport master (
        output in_valid, tc, a, b, out_ready,
        input  in_ready, out_valid, quotient, remainder, modulus, div_by_zero
    );

    // Divider side.
    modport slave (
        input  in_valid, tc, a, b, out_ready,
        output in_ready, out_valid, quotient, remainder, modulus, div_by_zero
    );
endinterface

// File: rtl/div_seq_unit.sv
// Restoring divider: one quotient bit per cycle, quotient/remainder/modulus, signed or unsigned.
// Latency: a_width+1 cycles from accept to out_valid; one operation in flight.
// Backpressure: results held in DONE until out_ready; in_ready only in IDLE.
module div_seq_unit #(
    parameter int a_width = 8,
    parameter int b_width = 8
) (
    input  logic           clk,
    input  logic           rst,
    div_seq_unit_if.slave  io
);
    localparam int CW = $clog2(a_width);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic               tc_q;
    logic               a_sign;
    logic               b_sign;
    logic [b_width-1:0] b_q;
    logic [b_width-1:0] a_low;
    logic [b_width-1:0] b_mag;
    logic [b_width-1:0] pr;
    logic [a_width-1:0] q_sr;

    logic               a_neg_in;
    logic               b_neg_in;
    logic [a_width-1:0] a_mag_in;
    logic [b_width-1:0] b_mag_in;
    logic [b_width:0]   shifted;
    logic               ge;
    logic [b_width-1:0] pr_nxt;
    logic [a_width-1:0] q_fix;
    logic [b_width-1:0] r_fix;
    logic [b_width-1:0] m_fix;
    logic               z_fix;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (io.in_valid) state_nxt = CALC;
            CALC:    if (cnt == '0)   state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        io.in_ready  = (state == IDLE);
        io.out_valid = (state == DONE);
    end

    // Operand magnitudes; negating the most-negative value leaves its bit pattern unchanged.
    always_comb begin
        a_neg_in = io.tc & io.a[a_width-1];
        b_neg_in = io.tc & io.b[b_width-1];
        a_mag_in = a_neg_in ? (~io.a + 1'b1) : io.a;
        b_mag_in = b_neg_in ? (~io.b + 1'b1) : io.b;
    end

    // One restoring step: the (b_width+1)-bit shifted partial remainder is trial-subtracted by |b|.
    // A kept difference is always below |b|, so b_width bits hold the stored remainder.
    always_comb begin
        shifted = {pr, q_sr[a_width-1]};
        ge      = (shifted >= {1'b0, b_mag});
        pr_nxt  = ge ? (shifted[b_width-1:0] - b_mag) : shifted[b_width-1:0];
    end

    // Sign fix-up of the magnitude results, with divide-by-zero override.
    always_comb begin
        q_fix = (a_sign ^ b_sign) ? (~q_sr + 1'b1) : q_sr;
        r_fix = a_sign ? (~pr + 1'b1) : pr;
        m_fix = ((r_fix != '0) && (a_sign != b_sign)) ? (r_fix + b_q) : r_fix;
        z_fix = 1'b0;
        if (b_q == '0) begin
            z_fix = 1'b1;
            if (!tc_q)      q_fix = '1;
            else if (a_sign) q_fix = {1'b1, {(a_width-1){1'b0}}};
            else             q_fix = {1'b0, {(a_width-1){1'b1}}};
            r_fix = a_low;
            m_fix = a_low;
        end
    end

    // Operand capture at accept and iteration during CALC.
    always_ff @(posedge clk) begin
        if (state == IDLE && io.in_valid) begin
            tc_q   <= io.tc;
            a_sign <= a_neg_in;
            b_sign <= b_neg_in;
            b_q    <= io.b;
            a_low  <= io.a[b_width-1:0];
            b_mag  <= b_mag_in;
            q_sr   <= a_mag_in;
            pr     <= '0;
            cnt    <= CW'(a_width - 1);
        end else if (state == CALC) begin
            pr   <= pr_nxt;
            q_sr <= {q_sr[a_width-2:0], ge};
            cnt  <= cnt - 1'b1;
        end
    end

    // Result registers, loaded once in FIX and held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            io.quotient    <= '0;
            io.remainder   <= '0;
            io.modulus     <= '0;
            io.div_by_zero <= 1'b0;
        end else if (state == FIX) begin
            io.quotient    <= q_fix;
            io.remainder   <= r_fix;
            io.modulus     <= m_fix;
            io.div_by_zero <= z_fix;
        end
    end
endmodule

// File: doc/div_seq_unit.md
# div_seq_unit

Multi-cycle restoring divider that computes quotient, remainder (Verilog `%` semantics) and modulus (VHDL `mod` semantics) for unsigned or two's-complement operands. It produces one quotient bit per clock.
- Operand widths are independent parameters; signedness is selected per operation.
- Valid/ready handshakes on both the input and output sides let it sit in a pipelined datapath where a full combinational divide would not meet timing.
- It is the sequential, area-lean counterpart to the team's combinational divide functions.

## Interface
Parameters:
- `a_width`, default 8: dividend and quotient width, ≥ 2.
- `b_width`, default 8: divisor, remainder and modulus width, ≥ 2, ≤ `a_width`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands.
- `tc`  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- `a`  in  `a_width`  dividend.
- `b`  in  `b_width`  divisor.
- `out_valid`  out  1  results valid.
- `out_ready`  in  1  consumer takes results.
- `quotient`  out  `a_width`  quotient.
- `remainder`  out  `b_width`  remainder; sign follows the dividend.
- `modulus`  out  `b_width`  modulus; sign follows the divisor.
- `div_by_zero`  out  1  set when `b` == 0 for the held result.

## Operation
- **FSM states:** IDLE, CALC, FIX, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`, latch `tc`, `a`, `b`.
  - Latch the operand signs (MSBs when `tc`=1, else 0).
  - Latch magnitudes |a| and |b|; the negation of the most-negative value keeps its unsigned bit pattern.
  - Load an `a_width`-bit iteration counter; go to CALC.
- **CALC**, once per cycle for `a_width` cycles:
  - Shift the next dividend magnitude bit into a (`b_width`+1)-bit partial remainder.
  - Trial-subtract |b|.
  - If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - When the counter reaches 0, go to FIX.
- **FIX**, one cycle:
  - Quotient = magnitude quotient, negated if the signs differ.
  - Remainder = magnitude remainder, negated if the dividend sign is 1.
  - Modulus = remainder + b if remainder ≠ 0 and the dividend and divisor signs differ; else remainder.
  - Register all outputs; go to DONE.
- **DONE**
  - `out_valid` = 1 and outputs are held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready` = 0; there is no overlap of result hand-off with the next accept.
- **Divide by zero** (`b` == 0): CALC still runs its full length, so latency is fixed. In FIX, override the results:
  - `div_by_zero` = 1.
  - Unsigned: quotient = all ones.
  - `tc`=1 with a ≥ 0: quotient = 0111…1.
  - `tc`=1 with a < 0: quotient = 1000…0.
  - Remainder = modulus = `a` truncated to `b_width`.
- **Signed overflow** (`tc`=1, a = most negative, b = −1):
  - Quotient wraps to 1000…0.
  - Remainder = modulus = 0.
  - `div_by_zero` = 0.
- `in_valid` is ignored outside IDLE; `a`, `b` and `tc` may change freely after accept.
- **Reset:**
  - State → IDLE.
  - `quotient`, `remainder`, `modulus`, `div_by_zero`, `out_valid` → 0.
  - `in_ready` = 1 from the first cycle after reset.
  - Reset in CALC, FIX or DONE aborts the operation; no result is ever presented for it.

## Timing
- The accept edge is E (IDLE, `in_valid`=1).
- CALC occupies edges E+1 … E+`a_width`; FIX ends at edge E+`a_width`+1.
- `out_valid` rises after edge E+`a_width`+1, giving an accept-to-result latency of `a_width`+1 cycles.
- Handshake edge H (DONE, `out_ready`=1): `out_valid` falls and `in_ready` rises after H.
- Minimum issue interval is `a_width`+3 cycles (8-bit: 11).
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid`/`out_ready`.
- When `rst` and `in_valid` are high together, reset wins and the operand is not accepted.

## Test plan
All cases use `a_width` = `b_width` = 8.
1. **Unsigned divide, latency:** `tc`=0, a=200, b=7 → quotient=28, remainder=4, modulus=4, `div_by_zero`=0. `out_valid` rises exactly 9 cycles after accept.
2. **Signed, negative dividend:** `tc`=1, a=0xF9 (−7), b=2 → quotient=0xFD (−3), remainder=0xFF (−1), modulus=0x01.
3. **Signed, negative divisor:** `tc`=1, a=7, b=0xFE (−2) → quotient=0xFD, remainder=0x01, modulus=0xFF (−1).
4. **Corner cases:**
   - `tc`=0, 13/0 → quotient=0xFF, remainder=modulus=13, `div_by_zero`=1.
   - `tc`=1, 0xFB/0 → quotient=0x80, remainder=modulus=0xFB, `div_by_zero`=1.
   - `tc`=1, 0x80/0xFF → quotient=0x80, remainder=modulus=0.
5. **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → outputs and `out_valid` stay stable and `in_ready`=0. Raise `out_ready` → next cycle `in_ready`=1; a new operand is accepted on the following edge.
6. **Reset mid-operation:** assert `rst` on the 3rd CALC cycle → next cycle all outputs 0, `in_ready`=1, `out_valid` never asserts for the aborted operation. A subsequent 100/10 gives quotient=10, remainder=0.
